effect_mixer_n: RTL and testbench
=================================

// Module: effect_mixer_n
// PURPOSE
//  N-channel audio effect mixer, generalising the 2-input effect mixer. Captures one parallel
//  sample set from the effect modules and applies a per-channel enable and unsigned gain.
//  Accumulates serially, one channel per cycle, then normalises and saturates.
//  Pushes one DATA_WIDTH sample into the output FIFO. Sits between the effect modules and the DAC FIFO.
// PARAMETERS
//  DATA_WIDTH  16  signed sample width (in and out)
//  NUM_CH      4   number of effect channels, 2..16
//  GAIN_WIDTH  8   unsigned gain width; unity gain = 2**(GAIN_WIDTH-1)
//  NORM_SHIFT  2   extra arithmetic right shift after gain removal (headroom for NUM_CH sum)
// PORTS
//  clk              in   1                    system clock, all logic on rising edge
//  reset_n          in   1                    asynchronous, active-low reset
//  i_ch_en          in   NUM_CH               per-channel enable (replaces 2-bit sw)
//  i_gain           in   NUM_CH*GAIN_WIDTH    packed gains, ch0 in LSBs
//  i_data_from_eff  in   NUM_CH*DATA_WIDTH    packed signed samples, ch0 in LSBs
//  i_dv_from_eff    in   1                    sample set valid
//  o_read_ready     out  1                    mixer can accept a sample set
//  o_read_done      out  1                    1-cycle pulse: sample set captured
//  i_fifo_full      in   1                    output FIFO full, back-pressure
//  o_data           out  DATA_WIDTH           mixed signed sample
//  o_data_valid     out  1                    1-cycle write strobe to FIFO
//  o_clip           out  1                    high with o_data_valid when the sample was saturated
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, acc=0, ch index=0; all outputs 0 (o_data, o_data_valid, o_read_done, o_clip, o_read_ready).
//   First edge after release sets o_read_ready=1.
//  FSM IDLE->ACC->NORM->OUTPUT->IDLE, all outputs registered:
//   IDLE: o_read_ready=1. On i_dv_from_eff & o_read_ready:
//    capture samples, i_ch_en and i_gain (later changes ignored until next capture);
//    acc=0, idx=0, o_read_ready<=0, o_read_done<=1 for exactly one cycle; goto ACC.
//   ACC: one channel per cycle; acc += ch_en[idx] ? sample[idx]*$signed({1'b0,gain[idx]}) : 0.
//    After idx==NUM_CH-1, goto NORM (NUM_CH cycles in ACC).
//   NORM: res = acc >>> (GAIN_WIDTH-1+NORM_SHIFT), arithmetic, truncates toward -inf.
//    Reduce res to DATA_WIDTH per CONFIGURATION; register it into the output holding register; goto OUTPUT.
//   OUTPUT: while i_fifo_full=1, stay and hold o_data stable with o_data_valid=0.
//    The first edge with i_fifo_full=0 sets o_data_valid=1 (and o_clip) for one cycle, sets o_read_ready<=1, goto IDLE.
//  Latency: accept edge k -> o_data_valid high in the cycle after edge k+NUM_CH+2 (FIFO not full).
//   Throughput is one sample per NUM_CH+3 cycles.
//  Width: product is DATA_WIDTH+GAIN_WIDTH+1 signed; acc is DATA_WIDTH+GAIN_WIDTH+1+clog2(NUM_CH) signed, so it never overflows.
//  All channels disabled -> o_data=0, o_clip=0, still written to the FIFO.
//  i_dv_from_eff outside IDLE is ignored; the data must be re-presented (the source holds until o_read_done).
//  Gain 0 on an enabled channel contributes 0. o_data holds its value between strobes.
// CONFIGURATION
//  EFFECT_MIXER_SAT_EN defined: res outside [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1] clamps to that bound, and o_clip=1.
//  Undefined: o_data = res[DATA_WIDTH-1:0] (two's-complement wrap); o_clip is tied to 0.
// STRUCTURE
//  Shared package audio_fx_pkg: FSM state encoding (IDLE/ACC/NORM/OUTPUT, 2 bits), clog2 function,
//   and an ACC_WIDTH helper function shared with the other effect blocks.
//  Sub-module effect_sat: parametrised signed narrowing (IN_W->OUT_W) with clip flag; both macro branches live in it.
// TESTING (DATA_WIDTH=16, NUM_CH=4, GAIN_WIDTH=8, NORM_SHIFT=2 unless noted)
//  1 Reset: assert reset_n=0 mid-ACC -> all outputs 0 immediately, no o_data_valid; release -> o_read_ready=1 one edge later.
//  2 All 4 ch =1000, gains=128, en=4'hF -> o_data=1000, o_clip=0, o_data_valid pulse 6 cycles after accept, o_read_done 1 cycle.
//  3 en=4'b0001, ch0=-8000, gain0=128 -> o_data=-2000; then en=4'b0001, ch0=1000, gain0=64 -> o_data=125.
//  4 NORM_SHIFT=0, all 4 ch=20000, gains=128: with EFFECT_MIXER_SAT_EN -> 32767, o_clip=1; without -> 14464, o_clip=0.
//  5 i_fifo_full=1 for 10 cycles at OUTPUT -> o_data_valid=0 and o_data stable; full drops -> single valid pulse.
//   i_dv_from_eff held high meanwhile -> no second capture until IDLE.
//  6 en=4'h0 with nonzero data -> o_data=0 written; back-to-back sets -> exactly one o_data_valid per o_read_done.

Source files
------------

// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effect blocks: mixer FSM encoding and width helpers.
// Pure package, no logic; imported by effect_mixer_n and the other effect modules.
package audio_fx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_NORM   = 2'd2,
        ST_OUTPUT = 2'd3
    } fx_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Signed accumulator wide enough to sum n_ch full-scale sample*gain products.
    function automatic int acc_width(input int data_w, input int gain_w, input int n_ch);
        return data_w + gain_w + 1 + clog2(n_ch);
    endfunction

endpackage

// File: rtl/effect_sat.sv
// Signed narrowing IN_W->OUT_W with clip flag; combinational, no backpressure.
// EFFECT_MIXER_SAT_EN selects clamp-to-range, otherwise two's-complement wrap with o_clip tied low.
module effect_sat #(
    parameter int IN_W  = 30,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout,
    output logic                    o_clip
);

`ifdef EFFECT_MIXER_SAT_EN
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    always_comb begin
        o_dout = i_din[OUT_W-1:0];
        o_clip = 1'b0;
        if (i_din > MAX_V) begin
            o_dout = MAX_V[OUT_W-1:0];
            o_clip = 1'b1;
        end else if (i_din < MIN_V) begin
            o_dout = MIN_V[OUT_W-1:0];
            o_clip = 1'b1;
        end
    end
`else
    logic [IN_W-OUT_W-1:0] w_unused_hi;

    assign o_dout      = i_din[OUT_W-1:0];
    assign o_clip      = 1'b0;
    assign w_unused_hi = i_din[IN_W-1:OUT_W];
`endif

endmodule

// File: rtl/effect_mixer_n.sv
// N-channel effect mixer: gain/enable per channel, serial MAC, normalise, saturate (EFFECT_MIXER_SAT_EN).
// Latency NUM_CH+2 edges from accept to write strobe; one sample per NUM_CH+3 cycles.
// Holds the result while i_fifo_full is high; accepts a new sample set only in IDLE.
module effect_mixer_n
    import audio_fx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int GAIN_WIDTH = 8,
    parameter int NORM_SHIFT = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_CH-1:0]                i_ch_en,
    input  logic [NUM_CH*GAIN_WIDTH-1:0]     i_gain,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     i_data_from_eff,
    input  logic                             i_dv_from_eff,
    output logic                             o_read_ready,
    output logic                             o_read_done,
    input  logic                             i_fifo_full,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic                             o_data_valid,
    output logic                             o_clip
);

    localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int ACC_W  = acc_width(DATA_WIDTH, GAIN_WIDTH, NUM_CH);
    localparam int IDX_W  = clog2(NUM_CH);
    localparam int SHIFT  = GAIN_WIDTH - 1 + NORM_SHIFT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    fx_state_t                       r_state;
    logic [NUM_CH*DATA_WIDTH-1:0]    r_samples;
    logic [NUM_CH*GAIN_WIDTH-1:0]    r_gain;
    logic [NUM_CH-1:0]               r_en;
    logic [IDX_W-1:0]                r_idx;
    logic signed [ACC_W-1:0]         r_acc;
    logic [DATA_WIDTH-1:0]           r_data;
    logic                            r_sat_clip;
    logic                            r_clip;
    logic                            r_valid;
    logic                            r_read_ready;
    logic                            r_read_done;

    logic signed [DATA_WIDTH-1:0]    w_sample;
    logic [GAIN_WIDTH-1:0]           w_gain;
    logic signed [PROD_W-1:0]        w_prod;
    logic signed [ACC_W-1:0]         w_res;
    logic signed [DATA_WIDTH-1:0]    w_sat_data;
    logic                            w_sat_clip;

    // Gain is unsigned: prepend a zero so the signed multiply treats it as positive.
    always_comb begin
        w_sample = $signed(r_samples[r_idx*DATA_WIDTH +: DATA_WIDTH]);
        w_gain   = r_gain[r_idx*GAIN_WIDTH +: GAIN_WIDTH];
        w_prod   = '0;
        if (r_en[r_idx]) begin
            w_prod = PROD_W'(w_sample) * PROD_W'($signed({1'b0, w_gain}));
        end
        w_res = r_acc >>> SHIFT;
    end

    effect_sat #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_WIDTH)
    ) u_sat (
        .i_din  (w_res),
        .o_dout (w_sat_data),
        .o_clip (w_sat_clip)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_samples    <= '0;
            r_gain       <= '0;
            r_en         <= '0;
            r_idx        <= '0;
            r_acc        <= '0;
            r_data       <= '0;
            r_sat_clip   <= 1'b0;
            r_clip       <= 1'b0;
            r_valid      <= 1'b0;
            r_read_ready <= 1'b0;
            r_read_done  <= 1'b0;
        end else begin
            r_read_done <= 1'b0;
            r_valid     <= 1'b0;
            r_clip      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_read_ready <= 1'b1;
                    if (i_dv_from_eff && r_read_ready) begin
                        r_samples    <= i_data_from_eff;
                        r_gain       <= i_gain;
                        r_en         <= i_ch_en;
                        r_acc        <= '0;
                        r_idx        <= '0;
                        r_read_ready <= 1'b0;
                        r_read_done  <= 1'b1;
                        r_state      <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= ST_NORM;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_NORM: begin
                    r_data     <= w_sat_data;
                    r_sat_clip <= w_sat_clip;
                    r_state    <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (!i_fifo_full) begin
                        r_valid      <= 1'b1;
                        r_clip       <= r_sat_clip;
                        r_read_ready <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_read_ready = r_read_ready;
    assign o_read_done  = r_read_done;
    assign o_data       = r_data;
    assign o_data_valid = r_valid;
    assign o_clip       = r_clip;

endmodule

// File: tb/tb_effect_mixer_n.sv
// Directed bench for effect_mixer_n: default instance (NORM_SHIFT=2) plus a NORM_SHIFT=0 instance.
module tb_effect_mixer_n;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  en = '0;
    logic [31:0] gain = '0;
    logic [63:0] data = '0;
    logic        dv0 = 1'b0;
    logic        dv1 = 1'b0;
    logic        fifo_full = 1'b0;

    logic        rdy0, done0, vld0, clip0, rdy1, done1, vld1, clip1;
    logic [15:0] dat0, dat1;

    logic        sel = 1'b0;
    logic        w_rdy, w_done, w_vld, w_clip;
    logic [15:0] w_dat;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    effect_mixer_n #(.DATA_WIDTH(16), .NUM_CH(4), .GAIN_WIDTH(8), .NORM_SHIFT(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .i_ch_en(en), .i_gain(gain), .i_data_from_eff(data),
        .i_dv_from_eff(dv0), .o_read_ready(rdy0), .o_read_done(done0), .i_fifo_full(fifo_full),
        .o_data(dat0), .o_data_valid(vld0), .o_clip(clip0)
    );

    effect_mixer_n #(.DATA_WIDTH(16), .NUM_CH(4), .GAIN_WIDTH(8), .NORM_SHIFT(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .i_ch_en(en), .i_gain(gain), .i_data_from_eff(data),
        .i_dv_from_eff(dv1), .o_read_ready(rdy1), .o_read_done(done1), .i_fifo_full(fifo_full),
        .o_data(dat1), .o_data_valid(vld1), .o_clip(clip1)
    );

    assign w_rdy  = sel ? rdy1  : rdy0;
    assign w_done = sel ? done1 : done0;
    assign w_vld  = sel ? vld1  : vld0;
    assign w_clip = sel ? clip1 : clip0;
    assign w_dat  = sel ? dat1  : dat0;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] gain;
        logic [63:0] data;
        logic [15:0] exp_wrap;
        logic [15:0] exp_sat;
        logic        clip_sat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_data(input vec_t v);
`ifdef EFFECT_MIXER_SAT_EN
        return v.exp_sat;
`else
        return v.exp_wrap;
`endif
    endfunction

    function automatic logic exp_clip(input vec_t v);
`ifdef EFFECT_MIXER_SAT_EN
        return v.clip_sat;
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!w_rdy && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!w_rdy) chk("ready_timeout", 32'(w_rdy), 32'd1);
    endtask

    // Accept one sample set, check the handshake, latency, data and single-cycle strobe.
    task automatic run_set(input logic which, input vec_t v, input string name);
        int t;
        sel = which;
        #1;
        wait_ready();
        @(negedge clk);
        en = v.en; gain = v.gain; data = v.data;
        if (which) dv1 = 1'b1; else dv0 = 1'b1;
        @(posedge clk); #1;
        chk({name, "_read_done"}, 32'(w_done), 32'd1);
        chk({name, "_ready_low"}, 32'(w_rdy), 32'd0);
        @(negedge clk);
        dv0 = 1'b0; dv1 = 1'b0;
        data = 64'hDEAD_BEEF_0BAD_F00D;
        t = 0;
        while (!w_vld && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        chk({name, "_latency"}, 32'(t), 32'd6);
        chk({name, "_data"}, 32'(w_dat), 32'(exp_data(v)));
        chk({name, "_clip"}, 32'(w_clip), 32'(exp_clip(v)));
        @(posedge clk); #1;
        chk({name, "_pulse"}, 32'(w_vld), 32'd0);
        chk({name, "_hold"}, 32'(w_dat), 32'(exp_data(v)));
    endtask

    vec_t vecs[9];
    vec_t v_ns0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, nvld, ndone;
        vecs[0] = '{4'hF, 32'h8080_8080, 64'h03E8_03E8_03E8_03E8, 16'd1000, 16'd1000, 1'b0};
        vecs[1] = '{4'h1, 32'h0000_0080, 64'h0000_0000_0000_E0C0, 16'hF830, 16'hF830, 1'b0};
        vecs[2] = '{4'h1, 32'h0000_0040, 64'h0000_0000_0000_03E8, 16'd125, 16'd125, 1'b0};
        vecs[3] = '{4'hF, 32'hFFFF_FFFF, 64'h7FFF_7FFF_7FFF_7FFF, 16'hFEFE, 16'h7FFF, 1'b1};
        vecs[4] = '{4'hF, 32'hFFFF_FFFF, 64'h8000_8000_8000_8000, 16'h0100, 16'h8000, 1'b1};
        vecs[5] = '{4'h1, 32'h0000_0001, 64'h0000_0000_0000_FFFF, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[6] = '{4'hA, 32'h80FF_00FF, 64'h0FA0_7FFF_1388_7FFF, 16'd1000, 16'd1000, 1'b0};
        vecs[7] = '{4'h0, 32'h8080_8080, 64'h1234_5678_7FFF_8000, 16'd0, 16'd0, 1'b0};
        vecs[8] = '{4'hF, 32'h8080_8080, 64'h0200_07D0_F448_03E8, 16'd128, 16'd128, 1'b0};
        v_ns0   = '{4'hF, 32'h8080_8080, 64'h4E20_4E20_4E20_4E20, 16'd14464, 16'h7FFF, 1'b1};

        // Reset state and first edge after release
        #1;
        chk("rst_ready", 32'(rdy0), 32'd0);
        chk("rst_valid", 32'(vld0), 32'd0);
        chk("rst_data", 32'(dat0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_clip", 32'(clip0), 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("release_ready", 32'(rdy0), 32'd1);

        foreach (vecs[i]) run_set(1'b0, vecs[i], $sformatf("vec%0d", i));
        run_set(1'b1, v_ns0, "ns0_20000");

        // Reset asserted mid-ACC clears outputs at once
        sel = 1'b0;
        wait_ready();
        @(negedge clk);
        en = 4'hF; gain = 32'h8080_8080; data = 64'h03E8_03E8_03E8_03E8; dv0 = 1'b1;
        @(posedge clk); @(negedge clk);
        dv0 = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("midacc_ready", 32'(rdy0), 32'd0);
        chk("midacc_data", 32'(dat0), 32'd0);
        chk("midacc_done", 32'(done0), 32'd0);
        nvld = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (vld0 || clip0) nvld++;
        end
        chk("midacc_no_valid", 32'(nvld), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("midacc_release_ready", 32'(rdy0), 32'd1);

        // FIFO full holds the result; dv held high must not capture again
        fifo_full = 1'b1;
        @(negedge clk);
        en = 4'hF; gain = 32'h8080_8080; data = 64'h03E8_03E8_03E8_03E8; dv0 = 1'b1;
        @(posedge clk); #1;
        chk("full_read_done", 32'(done0), 32'd1);
        bad = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (vld0 || done0) bad++;
        end
        chk("full_no_strobe", 32'(bad), 32'd0);
        chk("full_data_stable", 32'(dat0), 32'd1000);
        @(negedge clk);
        fifo_full = 1'b0;
        @(posedge clk); #1;
        chk("full_release_valid", 32'(vld0), 32'd1);
        chk("full_release_data", 32'(dat0), 32'd1000);
        @(posedge clk); #1;
        chk("full_second_valid", 32'(vld0), 32'd0);
        chk("full_recapture", 32'(done0), 32'd1);
        @(negedge clk);
        dv0 = 1'b0;
        nvld = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (vld0) begin
                nvld++;
                chk("full_drain_data", 32'(dat0), 32'd1000);
            end
        end
        chk("full_drain_count", 32'(nvld), 32'd1);

        // Back-to-back all-disabled sets: one strobe per capture, zero data
        @(negedge clk);
        en = 4'h0; gain = 32'h8080_8080; data = 64'h7FFF_1234_8000_4321; dv0 = 1'b1;
        nvld = 0; ndone = 0; bad = 0;
        for (int c = 0; c < 31; c++) begin
            @(posedge clk); #1;
            if (done0) ndone++;
            if (vld0) begin
                nvld++;
                if (dat0 !== 16'd0 || clip0 !== 1'b0) bad++;
            end
            if (c == 20) begin
                @(negedge clk);
                dv0 = 1'b0;
            end
        end
        chk("b2b_done_count", 32'(ndone), 32'd3);
        chk("b2b_valid_count", 32'(nvld), 32'd3);
        chk("b2b_zero_data", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
